seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Iterative shift-add multiplier. It sits downstream of the ALU operand-select muxes.
//  It latches two WIDTH-bit operands on start_i and produces a 2*WIDTH-bit product
//  after WIDTH iterations. Signed and unsigned modes are supported.
//  The pipeline/control stalls on busy_o and captures result_o when done_o pulses.
// PARAMETERS
//  WIDTH   32   operand width in bits (>=4); product is 2*WIDTH bits
// PORTS
//  clk_i     in   1          clock, rising edge
//  rst_i     in   1          asynchronous, active-low reset
//  start_i   in   1          request; sampled only in IDLE or DONE
//  signed_i  in   1          1: two's-complement operands; 0: unsigned (latched with start)
//  src1_i    in   WIDTH      multiplicand (from operand mux)
//  src2_i    in   WIDTH      multiplier (from operand mux)
//  busy_o    out  1          1 while iterating (RUN)
//  done_o    out  1          1-cycle pulse; result_o valid
//  result_o  out  2*WIDTH    product; held until next accepted start or reset
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, busy_o=0, done_o=0, result_o=0, internal regs=0.
//  - Reset mid-RUN aborts the operation. No done_o is produced.
//  FSM states: IDLE, RUN, DONE.
//  - IDLE: start_i=1 -> RUN. Latch magnitudes of src1_i/src2_i and the sign flag.
//    Sign flag = signed_i & (src1_i[MSB]^src2_i[MSB]). Clear accumulator; iteration count=WIDTH.
//  - RUN: one multiplier bit per cycle (LSB first). Add the shifted multiplicand into the
//    accumulator when the bit is 1. Decrement the count.
//    When the count reaches 0 -> DONE. result_o <= sign ? -acc : acc, written on that edge.
//  - DONE: done_o=1 for exactly this cycle. start_i=1 -> RUN (back-to-back, new operands
//    latched); else -> IDLE.
//  Latency: start sampled at edge E0. busy_o=1 for cycles 1..WIDTH. done_o=1 in cycle WIDTH+1.
//  - Throughput: one result every WIDTH+1 cycles.
//  busy_o=1 only in RUN; done_o=1 only in DONE; both are registered (decoded from state reg).
//  Magnitude: signed negative operand -> two's-complement negate, held in WIDTH unsigned bits.
//  - -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1) with no overflow.
//  Accumulator is 2*WIDTH bits; no truncation. Worst signed case (-2^(W-1))^2 = 2^(2W-2) fits.
//  start_i during RUN is ignored (no queueing). src1_i/src2_i/signed_i changes during RUN
//  have no effect.
//  Either operand zero still takes the full WIDTH cycles (fixed latency, no early exit).
//  result_o changes only on the RUN->DONE edge or at reset.
// TESTING (WIDTH=32)
//  1. Unsigned: start with 7 x 6, signed_i=0 -> busy_o cycles 1..32.
//     done_o in cycle 33; result_o=64'd42.
//  2. Signed: -3 x 5, signed_i=1 -> result_o=64'hFFFF_FFFF_FFFF_FFF1. Also check -3 x -5 -> 64'd15.
//  3. Corners:
//     - 32'hFFFF_FFFF^2 unsigned -> 64'hFFFF_FFFE_0000_0001; same operands signed -> 64'd1.
//     - 32'h8000_0000^2 signed -> 64'h4000_0000_0000_0000.
//  4. start_i held high and operands changed during RUN -> ignored.
//     - One done_o at cycle 33 with the original product.
//     - Next operation starts from the DONE cycle (back-to-back; 2nd done_o at cycle 66).
//  5. Reset mid-op: assert rst_i=0 in cycle 10 of RUN -> outputs are 0 immediately and no
//     done_o follows. A new start after release gives a correct product at +33 cycles.
//  6. Hold: after done_o with start_i=0 for 100 cycles -> result_o stable, busy_o=0, done_o=0.

Source files
------------

// File: rtl/seq_multiplier.sv
// ============================================================================
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per cycle,
// signed/unsigned operands, 2*WIDTH-bit product.  Rev 1.0
// ============================================================================
`default_nettype none

module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     src1_i,
    input  logic [WIDTH-1:0]     src2_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [CNT_W-1:0]   count;
    logic               neg;
    logic               accept;
    logic               last;

    assign accept   = start_i && ((state == IDLE) || (state == DONE));
    assign last     = (count == CNT_W'(1));
    // The most negative value negates onto itself, which is exactly its
    // unsigned magnitude, so no extra bit is needed.
    assign mag1     = (signed_i && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    assign mag2     = (signed_i && src2_i[WIDTH-1]) ? -src2_i : src2_i;
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    assign busy_o   = (state == RUN);
    assign done_o   = (state == DONE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start_i ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            neg      <= 1'b0;
            result_o <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, mag1};
            mplier <= mag2;
            acc    <= '0;
            count  <= CNT_W'(WIDTH);
            neg    <= signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
        end else if (state == RUN) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (last) begin
                result_o <= neg ? -acc_next : acc_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// tb_seq_multiplier: randomized and directed checks of seq_multiplier against
// a cycle-schedule reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_multiplier;

    localparam int W = 32;

    logic            clk_i    = 1'b0;
    logic            rst_i    = 1'b0;
    logic            start_i  = 1'b0;
    logic            signed_i = 1'b0;
    logic [W-1:0]    src1_i   = '0;
    logic [W-1:0]    src2_i   = '0;
    logic            busy_o;
    logic            done_o;
    logic [2*W-1:0]  result_o;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .signed_i (signed_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic s);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Reference: phase 0 idle, 1..W busy, W+1 done; the product appears on
    // entry to the done phase.
    int             phase     = 0;
    logic [2*W-1:0] m_pending = '0;
    logic [2*W-1:0] m_result  = '0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            phase     <= 0;
            m_pending <= '0;
            m_result  <= '0;
        end else if (phase == 0 || phase == W + 1) begin
            if (start_i) begin
                phase     <= 1;
                m_pending <= ref_prod(src1_i, src2_i, signed_i);
            end else begin
                phase <= 0;
            end
        end else if (phase == W) begin
            phase    <= W + 1;
            m_result <= m_pending;
        end else begin
            phase <= phase + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("model busy", 64'(busy_o), 64'(phase >= 1 && phase <= W));
            check("model done", 64'(done_o), 64'(phase == W + 1));
            check("model result", result_o, m_result);
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [63:0] exp, input string name);
        int k;
        @(negedge clk_i);
        #1;
        src1_i   = a;
        src2_i   = b;
        signed_i = s;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        k = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk_i);
            if (i == 1) check({name, " busy c1"}, 64'(busy_o), 64'd1);
            if (done_o) begin
                k = i;
                break;
            end
        end
        check({name, " latency"}, 64'(k), 64'd33);
        check({name, " result"}, result_o, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k1;
        int k2;
        int nd;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;

        cmp_en = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset result", result_o, 64'd0);
        #1 rst_i = 1'b1;

        run_op(32'd7, 32'd6, 1'b0, 64'd42, "u7x6");
        run_op(-32'sd3, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s-3x5");
        run_op(-32'sd3, -32'sd5, 1'b1, 64'd15, "s-3x-5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "uFFxFF");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, "sFFxFF");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s8000sq");
        run_op(32'd0, 32'h1234_5678, 1'b0, 64'd0, "zero");

        // start held high through RUN, operands churned, back-to-back second op
        @(negedge clk_i);
        #1;
        src1_i = 32'd1234; src2_i = 32'd5678; signed_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        k1 = 0;
        k2 = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                if (k1 == 0) begin
                    k1 = i;
                    check("b2b first result", result_o, 64'd7006652);
                    #1;
                    src1_i = 32'hFFFF_FFF0; src2_i = 32'd100; signed_i = 1'b1;
                    @(posedge clk_i);
                    #1 start_i = 1'b0;
                end else begin
                    k2 = i;
                    check("b2b second result", result_o, 64'hFFFF_FFFF_FFFF_F9C0);
                    break;
                end
            end else begin
                #1;
                src1_i   = $urandom;
                src2_i   = $urandom;
                signed_i = 1'($urandom_range(0, 1));
            end
        end
        check("b2b first latency", 64'(k1), 64'd33);
        check("b2b second latency", 64'(k2), 64'd66);

        // reset in cycle 10 of RUN aborts with no done
        @(negedge clk_i);
        #1;
        src1_i = 32'd9; src2_i = 32'd9; signed_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        check("abort busy", 64'(busy_o), 64'd0);
        check("abort done", 64'(done_o), 64'd0);
        check("abort result", result_o, 64'd0);
        repeat (2) @(negedge clk_i);
        #1 rst_i = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) nd++;
        end
        check("abort no done", 64'(nd), 64'd0);
        run_op(32'd100000, 32'd300000, 1'b0, 64'd30000000000, "after abort");

        // hold with start low
        nd = 0;
        k1 = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (busy_o || done_o) nd++;
            if (result_o != 64'd30000000000) k1++;
        end
        check("hold busy/done", 64'(nd), 64'd0);
        check("hold result changes", 64'(k1), 64'd0);

        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'd0;
                default: ;
            endcase
            run_op(a, b, s, ref_prod(a, b, s), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
